image_fifo_burst_ctrl: RTL and testbench
========================================

Name: image_fifo_burst_ctrl

Overview:
- Drains the 64-bit read side of the image input FIFO (16-bit write, 64-bit read, async) into DDR write bursts.
- Watches the FIFO read water level and requests the DDR write arbiter once a full burst, or the frame tail, is buffered.
- On grant, streams exactly that many words with fifo_rd_en.
- Generates word addresses in a ring of NUM_FRAMES frame buffers and reports frame completion.

Parameters:
RD_DEPTH_WIDTH, 9, FIFO read-side depth width; water level is RD_DEPTH_WIDTH+1 bits
DATA_WIDTH, 64, FIFO read data / DDR write data width
BURST_LEN, 16, words per full burst (1..255, must be <= 2**RD_DEPTH_WIDTH)
FRAME_WORDS, 230400, 64-bit words per frame (1280x720x16b/64)
NUM_FRAMES, 3, frame buffers in the ring (1..4)
ADDR_WIDTH, 28, DDR word address width
BASE_ADDR, 0, word address of frame 0; frame n base = BASE_ADDR + n*FRAME_WORDS

Ports:
clk  in  1  clock; FIFO read clock and arbiter clock
tb_rst  in  1  reset, asynchronous, active-high
enable  in  1  level; allows a new frame to start
frame_start  in  1  single-cycle pulse, synchronous to clk
fifo_rd_water_level  in  RD_DEPTH_WIDTH+1  FIFO read-side fill level in words
fifo_rd_en  out  1  FIFO read strobe
fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en (no output register)
wr_req  out  1  burst request to the DDR write arbiter
wr_addr  out  ADDR_WIDTH  burst start word address; stable while wr_req=1
wr_len  out  8  burst length in words; stable while wr_req=1
wr_ack  in  1  arbiter grant, single cycle
wr_data  out  DATA_WIDTH  burst data
wr_data_valid  out  1  wr_data qualifier
wr_done  in  1  single-cycle pulse; burst committed
frame_done  out  1  single-cycle pulse after the last burst of a frame completes
cur_frame  out  2  index of the frame being written (or next to be written)
busy  out  1  1 in any state except IDLE
overrun_err  out  1  sticky; set when frame_start arrives while busy

Behaviour:
- Reset state:
  - All outputs 0, FSM in IDLE, frame index 0.
  - Remaining-word counter 0, address register BASE_ADDR.
  - overrun_err is cleared only by tb_rst.
- IDLE:
  - frame_start & enable -> ARMED.
  - frame_start & !enable is ignored and does not set overrun_err.
- ARMED (1 cycle):
  - remaining <= FRAME_WORDS; addr <= BASE_ADDR + cur_frame*FRAME_WORDS.
  - Then -> WAIT_DATA.
- WAIT_DATA:
  - Burst length is len = (remaining >= BURST_LEN) ? BURST_LEN : remaining.
  - When fifo_rd_water_level >= len -> REQ, with wr_addr=addr and wr_len=len registered on entry.
  - The water-level gate guarantees the FIFO is never read while empty.
- REQ:
  - wr_req held at 1 until the cycle wr_ack=1, then drops to 0 the next cycle.
  - Go to XFER; wr_ack sampled outside REQ is ignored.
- XFER:
  - fifo_rd_en=1 for exactly len consecutive cycles (read counter 8 bits).
  - wr_data_valid = fifo_rd_en delayed 1 cycle; wr_data = fifo_rd_data on those cycles.
  - After the last valid beat -> WAIT_DONE.
- WAIT_DONE:
  - On wr_done: addr += len, remaining -= len.
  - If the new remaining = 0: pulse frame_done for 1 cycle, cur_frame <= (cur_frame+1) mod NUM_FRAMES, -> IDLE.
  - Otherwise -> WAIT_DATA.
- frame_start when busy=1: ignored, the frame in progress continues, overrun_err <= 1.
- enable deasserted mid-frame: the current frame completes; no new frame starts.
- Widths:
  - Remaining counter is clog2(FRAME_WORDS+1) bits.
  - Address arithmetic is ADDR_WIDTH-bit unsigned; overflow wraps and is not checked.
- Tail burst: when FRAME_WORDS mod BURST_LEN != 0, the last burst is shorter and waits only for that many words.
- Reset mid-operation: wr_req, fifo_rd_en and wr_data_valid drop immediately (asynchronous); any partial burst is abandoned.

Test Plan:
Params FRAME_WORDS=40, BURST_LEN=16, NUM_FRAMES=3, BASE_ADDR=0x100 for all scenarios.
1. Prefill FIFO with 40 words, pulse frame_start with enable=1, grant 2 cycles after each req, wr_done 3 cycles after last beat -> bursts (addr,len) = (0x100,16), (0x110,16), (0x120,8); 40 valid beats in FIFO order; one frame_done; cur_frame=1.
2. Run 4 frames back-to-back -> frame bases 0x100, 0x128, 0x150, then 0x100 again; cur_frame sequence 1,2,0,1.
3. Water level held at 15 -> wr_req stays 0; raise to 16 -> wr_req=1 within 2 cycles with len=16.
4. Delay wr_ack by 20 cycles -> wr_req, wr_addr and wr_len stable for all 20 cycles; fifo_rd_en=0 until the cycle after the ack.
5. Pulse frame_start again during XFER of burst 2 -> overrun_err=1 (sticky), the frame still completes with 40 words; frame_start with enable=0 in IDLE -> no request.
6. Assert tb_rst during XFER beat 5 -> all outputs 0 within the same cycle, cur_frame=0; the next frame_start restarts at 0x100.

Source files
------------

// File: rtl/image_fifo_burst_ctrl_if.sv
// ----------------------------------------------------------------------------
// image_fifo_burst_ctrl_if
//
// Bus bundle between the image FIFO drain controller and its environment:
// the read side of the image FIFO plus the DDR write-arbiter handshake.
//
// Signals:
//   fifo_rd_water_level  FIFO read-side fill level in words
//   fifo_rd_en           FIFO read strobe
//   fifo_rd_data         FIFO read data, valid one cycle after fifo_rd_en
//   wr_req               burst request to the DDR write arbiter
//   wr_addr              burst start word address, stable while wr_req=1
//   wr_len               burst length in words, stable while wr_req=1
//   wr_ack               single-cycle arbiter grant
//   wr_data              burst write data
//   wr_data_valid        wr_data qualifier
//   wr_done              single-cycle pulse, burst committed
//
// Modports:
//   master  the controller side (drives FIFO read strobe and write burst)
//   slave   the FIFO / arbiter side
// ----------------------------------------------------------------------------
interface image_fifo_burst_ctrl_if #(
    parameter int unsigned RD_DEPTH_WIDTH = 9,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 28
);
    logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level;
    logic                    fifo_rd_en;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;

    logic                    wr_req;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [7:0]              wr_len;
    logic                    wr_ack;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_data_valid;
    logic                    wr_done;

    modport master (
        input  fifo_rd_water_level,
        input  fifo_rd_data,
        input  wr_ack,
        input  wr_done,
        output fifo_rd_en,
        output wr_req,
        output wr_addr,
        output wr_len,
        output wr_data,
        output wr_data_valid
    );

    modport slave (
        output fifo_rd_water_level,
        output fifo_rd_data,
        output wr_ack,
        output wr_done,
        input  fifo_rd_en,
        input  wr_req,
        input  wr_addr,
        input  wr_len,
        input  wr_data,
        input  wr_data_valid
    );
endinterface

// File: rtl/image_fifo_burst_ctrl.sv
// ----------------------------------------------------------------------------
// image_fifo_burst_ctrl
//
// Drains the 64-bit read side of the image input FIFO into DDR write bursts.
// A burst is requested once the FIFO holds a full burst (or the shorter frame
// tail); on grant exactly that many words are read and forwarded. Bursts walk
// through a ring of NUM_FRAMES frame buffers, one frame per frame_start.
//
// Ports:
//   clk          clock (FIFO read clock and arbiter clock)
//   tb_rst       asynchronous active-high reset
//   enable       level; allows a new frame to start
//   frame_start  single-cycle pulse requesting a new frame
//   bus          FIFO read side + DDR write-arbiter handshake (master modport)
//   frame_done   single-cycle pulse after the last burst of a frame commits
//   cur_frame    index of the frame being written (or next to be written)
//   busy         high in every state except idle
//   overrun_err  sticky; frame_start seen while busy
// ----------------------------------------------------------------------------
module image_fifo_burst_ctrl #(
    parameter int unsigned RD_DEPTH_WIDTH = 9,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned FRAME_WORDS    = 230400,
    parameter int unsigned NUM_FRAMES     = 3,
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                    clk,
    input  logic                    tb_rst,
    input  logic                    enable,
    input  logic                    frame_start,
    image_fifo_burst_ctrl_if.master bus,
    output logic                    frame_done,
    output logic [1:0]              cur_frame,
    output logic                    busy,
    output logic                    overrun_err
);

    localparam int unsigned REM_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StWaitData,
        StReq,
        StXfer,
        StWaitDone
    } state_e;

    state_e                  state_q;
    logic [REM_W-1:0]        remaining_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              rd_cnt_q;
    logic                    wr_req_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [7:0]              wr_len_q;
    logic                    rd_en_q;
    logic                    data_valid_q;
    logic                    frame_done_q;
    logic [1:0]              cur_frame_q;
    logic                    overrun_q;

    logic [RD_DEPTH_WIDTH:0] level;
    logic [7:0]              burst_len;
    logic                    level_ok;
    logic                    last_burst;
    logic [ADDR_WIDTH-1:0]   frame_base;
    logic [1:0]              next_frame;
    logic [DATA_WIDTH-1:0]   beat_data;

    assign level = bus.fifo_rd_water_level;

    always_comb begin
        // Full burst while enough of the frame is left, otherwise the tail.
        burst_len  = (32'(remaining_q) >= BURST_LEN) ? 8'(BURST_LEN) : 8'(remaining_q);
        // Gate on buffered words so the FIFO is never read while empty.
        level_ok   = 32'(level) >= 32'(burst_len);
        // wr_len_q never exceeds remaining_q, so equality marks the final burst.
        last_burst = (remaining_q == REM_W'(wr_len_q));
        frame_base = ADDR_WIDTH'(BASE_ADDR)
                   + ADDR_WIDTH'(cur_frame_q) * ADDR_WIDTH'(FRAME_WORDS);
        next_frame = (32'(cur_frame_q) >= NUM_FRAMES - 1) ? 2'd0 : cur_frame_q + 2'd1;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            addr_q       <= ADDR_WIDTH'(BASE_ADDR);
            rd_cnt_q     <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            rd_en_q      <= 1'b0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            cur_frame_q  <= 2'd0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Read data arrives one cycle after the strobe.
            data_valid_q <= rd_en_q;

            if (frame_start && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (frame_start && enable) begin
                        state_q <= StArmed;
                    end
                end

                StArmed: begin
                    remaining_q <= REM_W'(FRAME_WORDS);
                    addr_q      <= frame_base;
                    state_q     <= StWaitData;
                end

                StWaitData: begin
                    if (level_ok) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_len_q  <= burst_len;
                        state_q   <= StReq;
                    end
                end

                StReq: begin
                    if (bus.wr_ack) begin
                        wr_req_q <= 1'b0;
                        rd_en_q  <= 1'b1;
                        rd_cnt_q <= wr_len_q;
                        state_q  <= StXfer;
                    end
                end

                StXfer: begin
                    if (rd_en_q) begin
                        rd_cnt_q <= rd_cnt_q - 8'd1;
                        if (rd_cnt_q == 8'd1) begin
                            rd_en_q <= 1'b0;
                        end
                    end else begin
                        // Strobe already dropped: the final beat is on the bus now.
                        state_q <= StWaitDone;
                    end
                end

                StWaitDone: begin
                    if (bus.wr_done) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(wr_len_q);
                        remaining_q <= remaining_q - REM_W'(wr_len_q);
                        if (last_burst) begin
                            frame_done_q <= 1'b1;
                            cur_frame_q  <= next_frame;
                            state_q      <= StIdle;
                        end else begin
                            state_q <= StWaitData;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Data is forwarded unregistered; zero it outside valid beats.
    assign beat_data         = data_valid_q ? bus.fifo_rd_data : '0;

    assign bus.fifo_rd_en    = rd_en_q;
    assign bus.wr_req        = wr_req_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_len        = wr_len_q;
    assign bus.wr_data       = beat_data;
    assign bus.wr_data_valid = data_valid_q;

    assign frame_done        = frame_done_q;
    assign cur_frame         = cur_frame_q;
    assign busy              = (state_q != StIdle);
    assign overrun_err       = overrun_q;

endmodule

// File: tb/tb_image_fifo_burst_ctrl.sv
`timescale 1ns/1ps
module tb_image_fifo_burst_ctrl;

    localparam int unsigned RDW  = 9;
    localparam int unsigned DW   = 64;
    localparam int unsigned BL   = 16;
    localparam int unsigned FW   = 40;
    localparam int unsigned NF   = 3;
    localparam int unsigned AW   = 28;
    localparam int unsigned BASE = 32'h100;

    logic       clk         = 1'b0;
    logic       tb_rst      = 1'b1;
    logic       enable      = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_done;
    logic [1:0] cur_frame;
    logic       busy;
    logic       overrun_err;

    image_fifo_burst_ctrl_if #(
        .RD_DEPTH_WIDTH (RDW),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW)
    ) bus ();

    image_fifo_burst_ctrl #(
        .RD_DEPTH_WIDTH (RDW),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BL),
        .FRAME_WORDS    (FW),
        .NUM_FRAMES     (NF),
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .enable      (enable),
        .frame_start (frame_start),
        .bus         (bus),
        .frame_done  (frame_done),
        .cur_frame   (cur_frame),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    initial forever #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [27:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_cf[$];

    // ---------------- FIFO model ----------------
    logic [63:0] fifo_q[$];
    logic [9:0]  model_level = '0;
    logic        lvl_ovr     = 1'b0;
    logic [9:0]  lvl_val     = '0;
    int          word_seq    = 0;

    assign bus.fifo_rd_water_level = lvl_ovr ? lvl_val : model_level;

    always @(negedge clk) model_level <= 10'(fifo_q.size());

    always @(posedge clk) begin
        if (tb_rst) begin
            bus.fifo_rd_data <= '0;
        end else if (bus.fifo_rd_en) begin
            check("fifo_not_empty_on_read", 64'(fifo_q.size() > 0), 64'd1);
            if (fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] w;
            w = 64'hC0DE_0000_0000_0000 | 64'(word_seq);
            word_seq++;
            fifo_q.push_back(w);
            exp_data.push_back(w);
        end
    endtask

    // Three bursts per 40-word frame: 16, 16, then an 8-word tail.
    task automatic expect_frame(input logic [27:0] base, input logic [1:0] cf_after);
        exp_req.push_back('{addr: base,          len: 8'd16});
        exp_req.push_back('{addr: base + 28'h10, len: 8'd16});
        exp_req.push_back('{addr: base + 28'h20, len: 8'd8});
        exp_cf.push_back(cf_after);
    endtask

    // ---------------- arbiter / DDR model ----------------
    int ack_delay  = 2;
    int done_delay = 3;
    int arb_st, arb_cnt, arb_beats, arb_len;

    always @(negedge clk) begin
        if (tb_rst) begin
            arb_st      = 0;
            bus.wr_ack  = 1'b0;
            bus.wr_done = 1'b0;
        end else begin
            case (arb_st)
                0: begin
                    bus.wr_done = 1'b0;
                    if (bus.wr_req) begin
                        arb_len = int'(bus.wr_len);
                        arb_cnt = 0;
                        arb_st  = 1;
                    end
                end
                1: begin
                    arb_cnt++;
                    if (arb_cnt >= ack_delay) begin
                        bus.wr_ack = 1'b1;
                        arb_beats  = 0;
                        arb_st     = 2;
                    end
                end
                2: begin
                    bus.wr_ack = 1'b0;
                    arb_st     = 3;
                end
                3: begin
                    if (bus.wr_data_valid) arb_beats++;
                    if (arb_beats >= arb_len) begin
                        arb_cnt = 0;
                        arb_st  = 4;
                    end
                end
                4: begin
                    arb_cnt++;
                    if (arb_cnt >= done_delay) begin
                        bus.wr_done = 1'b1;
                        arb_st      = 5;
                    end
                end
                default: begin
                    bus.wr_done = 1'b0;
                    arb_st      = 0;
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic req_active  = 1'b0;
    logic req_has_exp = 1'b0;
    req_t cur_req;
    int   req_rises   = 0;
    int   beat_cnt    = 0;
    int   frames_done = 0;

    always @(negedge clk) begin
        if (!tb_rst) begin
            if (bus.wr_req) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    req_rises++;
                    if (exp_req.size() == 0) begin
                        req_has_exp = 1'b0;
                        check("unexpected_wr_req_addr", 64'(bus.wr_addr), 64'hFFFF_FFFF);
                    end else begin
                        req_has_exp = 1'b1;
                        cur_req = exp_req.pop_front();
                    end
                end
                if (req_has_exp) begin
                    check("wr_addr", 64'(bus.wr_addr), 64'(cur_req.addr));
                    check("wr_len", 64'(bus.wr_len), 64'(cur_req.len));
                end
            end else begin
                req_active = 1'b0;
            end

            if (bus.fifo_rd_en) check("rd_en_while_req", 64'(bus.wr_req), 64'd0);

            if (bus.wr_data_valid) begin
                beat_cnt++;
                if (exp_data.size() == 0) check("unexpected_beat", bus.wr_data, 64'hDEAD);
                else check("wr_data", bus.wr_data, exp_data.pop_front());
            end

            if (frame_done) begin
                frames_done++;
                if (exp_cf.size() == 0) check("unexpected_frame_done", 64'(cur_frame), 64'd7);
                else check("cur_frame_at_done", 64'(cur_frame), 64'(exp_cf.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic flush_all();
        fifo_q.delete();
        exp_req.delete();
        exp_data.delete();
        exp_cf.delete();
        beat_cnt  = 0;
        req_rises = 0;
        lvl_ovr   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        tb_rst      = 1'b1;
        frame_start = 1'b0;
        flush_all();
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(frames_done >= target), 64'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_req_left"}, 64'(exp_req.size()), 64'd0);
        check({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
        check({tag, "_done_left"}, 64'(exp_cf.size()), 64'd0);
    endtask

    logic [27:0] bases[4] = '{28'h100, 28'h128, 28'h150, 28'h100};
    logic [1:0]  cfs[4]   = '{2'd1, 2'd2, 2'd0, 2'd1};

    initial begin
        int   cnt;
        logic seen;
        logic rd_seen;

        bus.fifo_rd_data = '0;
        apply_reset();

        // Reset state
        check("rst_wr_req", 64'(bus.wr_req), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_valid", 64'(bus.wr_data_valid), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_len", 64'(bus.wr_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_frame", 64'(cur_frame), 64'd0);
        check("rst_overrun", 64'(overrun_err), 64'd0);

        // 1: single frame, three bursts incl. 8-word tail
        enable = 1'b1;
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        wait_frames(frames_done + 1, 600, "s1_frame_done_timeout");
        repeat (3) @(negedge clk);
        check("s1_cur_frame", 64'(cur_frame), 64'd1);
        check("s1_beats", 64'(beat_cnt), 64'd40);
        check("s1_bursts", 64'(req_rises), 64'd3);
        check("s1_busy_after", 64'(busy), 64'd0);
        check_drained("s1");

        // 2: four frames back-to-back through the ring
        apply_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_words(40);
            expect_frame(bases[k], cfs[k]);
            pulse_start();
            wait_frames(frames_done + 1, 600, "s2_frame_done_timeout");
            repeat (2) @(negedge clk);
            check("s2_cur_frame", 64'(cur_frame), 64'(cfs[k]));
        end
        check("s2_beats", 64'(beat_cnt), 64'd160);
        check_drained("s2");

        // 3: water level gating
        apply_reset();
        enable  = 1'b1;
        lvl_ovr = 1'b1;
        lvl_val = 10'd15;
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s3_no_req_at_15", 64'(bus.wr_req), 64'd0);
        end
        check("s3_busy_waiting", 64'(busy), 64'd1);
        lvl_val = 10'd16;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.wr_req) seen = 1'b1;
        end
        check("s3_req_after_16", 64'(seen), 64'd1);
        check("s3_len", 64'(bus.wr_len), 64'd16);
        lvl_ovr = 1'b0;
        wait_frames(frames_done + 1, 600, "s3_frame_done_timeout");
        repeat (2) @(negedge clk);
        check_drained("s3");

        // 4: delayed grant
        apply_reset();
        enable    = 1'b1;
        ack_delay = 20;
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        cnt = 0;
        while (!bus.wr_req && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("s4_req_seen", 64'(bus.wr_req), 64'd1);
        cnt     = 1;
        rd_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.wr_req) break;
            cnt++;
            if (bus.fifo_rd_en) rd_seen = 1'b1;
        end
        ack_delay = 2;
        check("s4_req_cycles", 64'(cnt), 64'd21);
        check("s4_no_rd_during_req", 64'(rd_seen), 64'd0);
        check("s4_rd_en_after_ack", 64'(bus.fifo_rd_en), 64'd1);
        wait_frames(frames_done + 1, 800, "s4_frame_done_timeout");
        repeat (2) @(negedge clk);
        check("s4_beats", 64'(beat_cnt), 64'd40);
        check_drained("s4");

        // 5: start ignored when disabled; overrun during transfer
        apply_reset();
        enable = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("s5_disabled_no_req", 64'(bus.wr_req), 64'd0);
        end
        check("s5_disabled_busy", 64'(busy), 64'd0);
        check("s5_disabled_no_overrun", 64'(overrun_err), 64'd0);
        enable = 1'b1;
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        cnt = 0;
        while (!(req_rises == 2 && bus.fifo_rd_en) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("s5_reached_burst2_xfer", 64'(req_rises == 2 && bus.fifo_rd_en), 64'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("s5_overrun_set", 64'(overrun_err), 64'd1);
        wait_frames(frames_done + 1, 600, "s5_frame_done_timeout");
        repeat (10) @(negedge clk);
        check("s5_overrun_sticky", 64'(overrun_err), 64'd1);
        check("s5_beats", 64'(beat_cnt), 64'd40);
        check("s5_bursts", 64'(req_rises), 64'd3);
        check("s5_idle_after", 64'(busy), 64'd0);
        check_drained("s5");

        // 6: reset in the middle of a burst
        apply_reset();
        enable = 1'b1;
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        wait_frames(frames_done + 1, 600, "s6_first_frame_timeout");
        push_words(40);
        expect_frame(28'h128, 2'd2);
        beat_cnt = 0;
        pulse_start();
        cnt = 0;
        while (beat_cnt < 4 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("s6_reached_beat5", 64'(beat_cnt >= 4), 64'd1);
        #2 tb_rst = 1'b1;
        #1;
        check("s6_rst_wr_req", 64'(bus.wr_req), 64'd0);
        check("s6_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("s6_rst_valid", 64'(bus.wr_data_valid), 64'd0);
        check("s6_rst_wr_data", bus.wr_data, 64'd0);
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_cur_frame", 64'(cur_frame), 64'd0);
        check("s6_rst_frame_done", 64'(frame_done), 64'd0);
        flush_all();
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        repeat (2) @(negedge clk);
        push_words(40);
        expect_frame(28'h100, 2'd1);
        pulse_start();
        wait_frames(frames_done + 1, 600, "s6_restart_frame_timeout");
        repeat (2) @(negedge clk);
        check("s6_cur_frame", 64'(cur_frame), 64'd1);
        check("s6_beats", 64'(beat_cnt), 64'd40);
        check_drained("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
